instr_prefetch: RTL

//  Prefetch unit upstream of the CPU decode stage. Issues sequential instruction

---
 rtl/instr_prefetch_pkg.sv | 12 +
 rtl/instr_prefetch_if.sv | 29 ++
 rtl/instr_prefetch_fifo.sv | 55 +++++
 rtl/instr_prefetch.sv | 87 ++++++++
 4 files changed

// File: rtl/instr_prefetch_pkg.sv
// Shared defaults and FSM encoding for the instruction prefetch unit.
package instr_prefetch_pkg;
    localparam int BITS_DATA_DEF = 32;
    localparam int BITS_ADDR_DEF = 16;
    localparam int DEPTH_DEF     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } pf_state_e;
endpackage

// File: rtl/instr_prefetch_if.sv
// Memory read port plus decode handshake and control of the prefetch unit.
interface instr_prefetch_if
    import instr_prefetch_pkg::*;
#(
    parameter int BITS_DATA = BITS_DATA_DEF,
    parameter int BITS_ADDR = BITS_ADDR_DEF
);
    logic [BITS_ADDR-1:0] mem_addr;
    logic                 mem_rd;
    logic                 mem_busy;
    logic [BITS_DATA-1:0] mem_rdata;
    logic [BITS_DATA-1:0] ir_data;
    logic [BITS_ADDR-1:0] ir_pc;
    logic                 ir_valid;
    logic                 ir_ready;
    logic                 redirect;
    logic [BITS_ADDR-1:0] redirect_pc;
    logic                 halt;

    modport master (
        output mem_addr, mem_rd, ir_data, ir_pc, ir_valid,
        input  mem_busy, mem_rdata, ir_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  mem_addr, mem_rd, ir_data, ir_pc, ir_valid,
        output mem_busy, mem_rdata, ir_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/instr_prefetch_fifo.sv
// Synchronous FIFO holding {pc, word} pairs between memory response and decode.
module instr_fifo
    import instr_prefetch_pkg::*;
#(
    parameter int W     = BITS_DATA_DEF + BITS_ADDR_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Flush wins over push/pop; storage is left as-is since empty masks it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher: one outstanding read, FIFO to decode,
// redirect flush and halt.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int                   BITS_DATA = BITS_DATA_DEF,
    parameter int                   BITS_ADDR = BITS_ADDR_DEF,
    parameter int                   DEPTH     = DEPTH_DEF,
    parameter logic [BITS_ADDR-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    instr_prefetch_if.master  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [BITS_ADDR-1:0]           fetch_pc, req_pc;
    logic                           inflight, room, accept, push, pop, empty;
    logic [CW-1:0]                  count;
    logic [BITS_ADDR+BITS_DATA-1:0] head;
    pf_state_e                      state_q, state_d;

    // Reserve a slot for the outstanding read so a response always fits.
    assign room   = ({1'b0, count} + {{CW{1'b0}}, inflight}) < (CW+1)'(DEPTH);
    assign accept = bus.mem_rd & ~bus.mem_busy;
    // A response returning during redirect is stale and simply not pushed.
    assign push   = inflight & ~bus.redirect;
    assign pop    = bus.ir_valid & bus.ir_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!bus.halt) state_d = room ? ST_FETCH : ST_WAIT;
            ST_FETCH: if (bus.halt) state_d = ST_IDLE;
                      else if (!room) state_d = ST_WAIT;
            ST_WAIT:  if (bus.halt) state_d = ST_IDLE;
                      else if (room) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Issue decision follows the next state so release and halt act this cycle.
    always_comb begin
        bus.mem_rd   = reset && !bus.redirect && (state_d == ST_FETCH);
        bus.mem_addr = reset ? fetch_pc : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + BITS_ADDR'(1);
            end
        end
    end

    instr_fifo #(
        .W     (BITS_ADDR + BITS_DATA),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({req_pc, bus.mem_rdata}),
        .pop   (pop),
        .flush (bus.redirect),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

    assign bus.ir_valid           = ~empty;
    assign {bus.ir_pc, bus.ir_data} = head;
endmodule
